// File: rtl/ptr_list_collector_pkg.sv
// Shared types for the pointer-list collector: pointer width, element and
// summary records, FSM state encoding and the saturating length increment.
package ptr_list_collector_pkg;

    localparam int n     = 16;
    localparam int Width = $clog2(n);

    typedef logic [Width-1:0] Pointer;
    typedef logic [Width:0]   len_t;

    // One buffered list element with its list-boundary flags.
    typedef struct packed {
        Pointer ptr;
        logic   first;
        logic   last;
    } elem_t;

    // Per-list summary: element count and XOR signature.
    typedef struct packed {
        len_t   len;
        Pointer sig;
    } sum_t;

    // EMPTY: no beat pending. HOLD: one beat waits to learn whether it is a tail.
    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Length counter increment that sticks at all-ones.
    function automatic len_t len_sat_inc(input len_t v);
        return (&v) ? v : len_t'(v + 1'b1);
    endfunction

endpackage

// File: rtl/ptr_list_collector_fifo.sv
// Parameterised synchronous FIFO. Output data comes straight from the storage
// registers and reads as zero while empty. A push into a full FIFO is ignored
// unless a pop happens in the same cycle; a pop from an empty FIFO is ignored.
module ptr_fifo #(
    parameter int  Depth = 8,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);

    localparam int             AW       = $clog2(Depth);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(Depth);

    T              mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? T'('0) : mem[rd_ptr];

    // Storage write; entries need no reset because empty masks the output.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at Depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ptr_list_collector.sv
// Splits a non-stallable pointer stream into lists, tags first/last on each
// element, buffers elements and per-list {length, XOR signature} summaries.
// The upstream cannot be stalled, so FIFO overruns raise a sticky overflow.
module ptr_list_collector
    import ptr_list_collector_pkg::*;
#(
    parameter int Depth    = 8,
    parameter int SumDepth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] in_ptr,
    input  logic             in_ptr_vld,
    input  logic             in_first,
    output logic [Width-1:0] elem_ptr,
    output logic             elem_first,
    output logic             elem_last,
    output logic             elem_vld,
    input  logic             elem_rdy,
    output logic [Width:0]   sum_len,
    output logic [Width-1:0] sum_sig,
    output logic             sum_vld,
    input  logic             sum_rdy,
    output logic             overflow,
    output state_t           fsm_state
);

    // Handshake: an element (summary) transfers on a cycle where both its
    // vld and rdy are high; vld never depends on rdy. The input side has no
    // ready: every in_ptr_vld beat is consumed in the cycle it is presented.

    state_t state;
    Pointer pend_ptr;
    logic   pend_first;
    len_t   acc_len;
    Pointer acc_sig;
    logic   overflow_q;

    logic   pend_is_last;
    logic   elem_push;
    logic   sum_push;
    len_t   len_next;
    Pointer sig_next;
    elem_t  elem_in;
    elem_t  elem_out;
    sum_t   sum_in;
    sum_t   sum_out;
    logic   elem_full;
    logic   elem_empty;
    logic   sum_full;
    logic   sum_empty;

    // The pending beat is a tail when the stream pauses or a new list starts now.
    always_comb begin
        pend_is_last = ~in_ptr_vld | in_first;
        elem_push    = (state == HOLD);
        sum_push     = (state == HOLD) & pend_is_last;
        len_next     = len_sat_inc(acc_len);
        sig_next     = acc_sig ^ pend_ptr;
        elem_in      = '{ptr: pend_ptr, first: pend_first, last: pend_is_last};
        sum_in       = '{len: len_next, sig: sig_next};
    end

    // List FSM with the pending-beat register and per-list accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            pend_ptr   <= '0;
            pend_first <= 1'b0;
            acc_len    <= '0;
            acc_sig    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_ptr_vld) begin
                        pend_ptr   <= in_ptr;
                        pend_first <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    // Accumulators track pushed elements; a close restarts them.
                    if (pend_is_last) begin
                        acc_len <= '0;
                        acc_sig <= '0;
                    end else begin
                        acc_len <= len_next;
                        acc_sig <= sig_next;
                    end
                    if (in_ptr_vld) begin
                        pend_ptr   <= in_ptr;
                        pend_first <= in_first;
                    end else begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Sticky flag for any element or summary lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if ((elem_push & elem_full & ~elem_rdy) |
                     (sum_push & sum_full & ~sum_rdy)) begin
            overflow_q <= 1'b1;
        end
    end

    ptr_fifo #(
        .Depth (Depth),
        .T     (elem_t)
    ) u_elem_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (elem_push),
        .push_data (elem_in),
        .pop       (elem_rdy),
        .pop_data  (elem_out),
        .full      (elem_full),
        .empty     (elem_empty)
    );

    ptr_fifo #(
        .Depth (SumDepth),
        .T     (sum_t)
    ) u_sum_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (sum_push),
        .push_data (sum_in),
        .pop       (sum_rdy),
        .pop_data  (sum_out),
        .full      (sum_full),
        .empty     (sum_empty)
    );

    assign elem_ptr   = elem_out.ptr;
    assign elem_first = elem_out.first;
    assign elem_last  = elem_out.last;
    assign elem_vld   = ~elem_empty;
    assign sum_len    = sum_out.len;
    assign sum_sig    = sum_out.sig;
    assign sum_vld    = ~sum_empty;
    assign overflow   = overflow_q;
    assign fsm_state  = state;

endmodule
